// File: rtl/button_press_classifier.sv
// Classifies a debounced button into short/long/auto-repeat pulses; pulses are 1 cycle, 1 cycle after the deciding input, no backpressure.
// Optional auto-repeat in the long-hold state is enabled by defining BUTTON_REPEAT_EN.
module button_press_classifier #(
    parameter int LONG_TICKS   = 1024,
    parameter int REPEAT_TICKS = 256,
    parameter int CNT_W        = 11
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Button,
    input  logic i_Enable_Tick,
    output logic o_Short_Press,
    output logic o_Long_Press,
    output logic o_Repeat,
    output logic o_Held
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHORT = 2'd1;
    localparam logic [1:0] S_LONG  = 2'd2;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

    logic [1:0]       r_State;
    logic [CNT_W-1:0] r_Count;
    logic             r_Button_Prev;
    logic             r_Short;
    logic             r_Long;
    logic             r_Repeat;
    logic             r_Held;

    logic             w_Press;
    logic [CNT_W-1:0] w_Last;
    logic             w_At_Last;

    assign w_Press   = i_Button & ~r_Button_Prev;
    assign w_Last    = (r_State == S_LONG) ? REP_LAST : LONG_LAST;
    assign w_At_Last = (r_Count == w_Last);

    // r_Button_Prev resets to 1 so a button held through reset needs a fresh press.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State       <= S_IDLE;
            r_Count       <= '0;
            r_Button_Prev <= 1'b1;
            r_Short       <= 1'b0;
            r_Long        <= 1'b0;
            r_Repeat      <= 1'b0;
            r_Held        <= 1'b0;
        end else begin
            r_Button_Prev <= i_Button;
            r_Short       <= 1'b0;
            r_Long        <= 1'b0;
            r_Repeat      <= 1'b0;
            case (r_State)
                S_IDLE: begin
                    if (w_Press) begin
                        r_State <= S_SHORT;
                        r_Held  <= 1'b1;
                        r_Count <= '0;
                    end
                end
                S_SHORT: begin
                    // Release takes priority over a coincident threshold tick.
                    if (!i_Button) begin
                        r_State <= S_IDLE;
                        r_Held  <= 1'b0;
                        r_Count <= '0;
                        r_Short <= 1'b1;
                    end else if (i_Enable_Tick) begin
                        if (w_At_Last) begin
                            r_State <= S_LONG;
                            r_Count <= '0;
                            r_Long  <= 1'b1;
                        end else begin
                            r_Count <= r_Count + 1'b1;
                        end
                    end
                end
                S_LONG: begin
                    if (!i_Button) begin
                        r_State <= S_IDLE;
                        r_Held  <= 1'b0;
                        r_Count <= '0;
`ifdef BUTTON_REPEAT_EN
                    end else if (i_Enable_Tick) begin
                        if (w_At_Last) begin
                            r_Count  <= '0;
                            r_Repeat <= 1'b1;
                        end else begin
                            r_Count <= r_Count + 1'b1;
                        end
`else
                    end else begin
                        r_Count <= '0;
`endif
                    end
                end
                default: begin
                    r_State <= S_IDLE;
                    r_Held  <= 1'b0;
                    r_Count <= '0;
                end
            endcase
        end
    end

    assign o_Short_Press = r_Short;
    assign o_Long_Press  = r_Long;
    assign o_Held        = r_Held;
`ifdef BUTTON_REPEAT_EN
    assign o_Repeat      = r_Repeat;
`else
    assign o_Repeat      = 1'b0;
`endif

endmodule
